// File: rtl/gol_pkg.sv
// Shared types and constants for the Game-of-Life row sequencer.
// Optional toroidal wrap is selected with the GOL_WRAP_EN macro.
package gol_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_LAST  = 3'd1,
        LOAD_FIRST = 3'd2,
        SWEEP      = 3'd3,
        DONE       = 3'd4
    } golState_e;

    // Eight neighbours at most, so four bits always suffice.
    localparam int CNT_W       = 4;
    localparam int GENBITS_DEF = 16;

    function automatic logic cellNext(input logic alive, input logic [CNT_W-1:0] count);
        return (count == CNT_W'(3)) || (alive && (count == CNT_W'(2)));
    endfunction

endpackage

// File: rtl/gol_sequencer_if.sv
// Control and row-register-file bus of the Game-of-Life sequencer.
// The slave modport is the sequencer side; master is the requester/register-file side.
interface gol_sequencer_if
    import gol_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3,
    parameter int GENBITS = GENBITS_DEF
);

    logic               start;
    logic               run;
    logic [WIDTH-1:0]   rd;
    logic [REGBITS-1:0] ra;
    logic               regwrite;
    logic [REGBITS-1:0] wa;
    logic [WIDTH-1:0]   wd;
    logic               busy;
    logic               done;
    logic [GENBITS-1:0] gen_count;

    modport master (
        output start, run, rd,
        input  ra, regwrite, wa, wd, busy, done, gen_count
    );

    modport slave (
        input  start, run, rd,
        output ra, regwrite, wa, wd, busy, done, gen_count
    );

endinterface

// File: rtl/gol_row_rule.sv
// Combinational Life rule for one row given the rows above and below.
// Edge columns wrap around when GOL_WRAP_EN is defined, otherwise they read as dead.
module gol_row_rule
    import gol_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] prev_i,
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] nxt_i,
    output logic [WIDTH-1:0] next_o
);

    // Extended rows: bit 0 is column -1, bit WIDTH+1 is column WIDTH.
    logic [WIDTH+1:0] prevExt;
    logic [WIDTH+1:0] curExt;
    logic [WIDTH+1:0] nxtExt;
    logic [CNT_W-1:0] count;

`ifdef GOL_WRAP_EN
    assign prevExt = {prev_i[0], prev_i, prev_i[WIDTH-1]};
    assign curExt  = {cur_i[0],  cur_i,  cur_i[WIDTH-1]};
    assign nxtExt  = {nxt_i[0],  nxt_i,  nxt_i[WIDTH-1]};
`else
    assign prevExt = {1'b0, prev_i, 1'b0};
    assign curExt  = {1'b0, cur_i,  1'b0};
    assign nxtExt  = {1'b0, nxt_i,  1'b0};
`endif

    always_comb begin
        next_o = '0;
        count  = '0;
        for (int c = 0; c < WIDTH; c++) begin
            count = CNT_W'(prevExt[c]) + CNT_W'(prevExt[c+1]) + CNT_W'(prevExt[c+2])
                  + CNT_W'(curExt[c])                        + CNT_W'(curExt[c+2])
                  + CNT_W'(nxtExt[c])  + CNT_W'(nxtExt[c+1]) + CNT_W'(nxtExt[c+2]);
            next_o[c] = cellNext(curExt[c+1], count);
        end
    end

endmodule

// File: rtl/gol_sequencer.sv
// Steps a row-stored Life grid one generation per request, rewriting rows in place.
// Define GOL_WRAP_EN for a toroidal grid; the default treats everything outside as dead.
module gol_sequencer
    import gol_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3,
    parameter int GENBITS = GENBITS_DEF
) (
    input  logic           ph2,
    input  logic           reset,
    gol_sequencer_if.slave bus
);

    localparam logic [REGBITS-1:0] LAST_ROW = '1;

    golState_e          state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [WIDTH-1:0]   cur_q, cur_d;
    logic [REGBITS-1:0] rowIdx_q, rowIdx_d;
    logic [GENBITS-1:0] genCount_q, genCount_d;
    logic [WIDTH-1:0]   nxtRow;
    logic [WIDTH-1:0]   ruleRow;
    logic [REGBITS-1:0] raC, waC;
    logic [WIDTH-1:0]   wdC;
    logic               regwriteC, busyC, doneC;

`ifdef GOL_WRAP_EN
    // Row 0 is overwritten first, so its original value is kept for the last row's lower neighbour.
    logic [WIDTH-1:0]   row0Save_q, row0Save_d;

    assign nxtRow = (rowIdx_q == LAST_ROW) ? row0Save_q : bus.rd;
`else
    assign nxtRow = (rowIdx_q == LAST_ROW) ? '0 : bus.rd;
`endif

    gol_row_rule #(
        .WIDTH (WIDTH)
    ) uRowRule (
        .prev_i (prev_q),
        .cur_i  (cur_q),
        .nxt_i  (nxtRow),
        .next_o (ruleRow)
    );

    always_ff @(posedge ph2) begin
        if (reset) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            cur_q      <= '0;
            rowIdx_q   <= '0;
            genCount_q <= '0;
`ifdef GOL_WRAP_EN
            row0Save_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            rowIdx_q   <= rowIdx_d;
            genCount_q <= genCount_d;
`ifdef GOL_WRAP_EN
            row0Save_q <= row0Save_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        rowIdx_d   = rowIdx_q;
        genCount_d = genCount_q;
`ifdef GOL_WRAP_EN
        row0Save_d = row0Save_q;
`endif
        raC        = '0;
        waC        = '0;
        wdC        = '0;
        regwriteC  = 1'b0;
        busyC      = 1'b0;
        doneC      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start || bus.run) begin
                    state_d = LOAD_LAST;
                end
            end
            LOAD_LAST: begin
                busyC   = 1'b1;
                raC     = LAST_ROW;
`ifdef GOL_WRAP_EN
                prev_d  = bus.rd;
`else
                prev_d  = '0;
`endif
                state_d = LOAD_FIRST;
            end
            LOAD_FIRST: begin
                busyC      = 1'b1;
                raC        = '0;
                cur_d      = bus.rd;
`ifdef GOL_WRAP_EN
                row0Save_d = bus.rd;
`endif
                rowIdx_d   = '0;
                state_d    = SWEEP;
            end
            // Reading row r+1 while writing row r keeps the read and write ports apart.
            SWEEP: begin
                busyC     = 1'b1;
                raC       = rowIdx_q + 1'b1;
                regwriteC = 1'b1;
                waC       = rowIdx_q;
                wdC       = ruleRow;
                prev_d    = cur_q;
                cur_d     = nxtRow;
                rowIdx_d  = rowIdx_q + 1'b1;
                if (rowIdx_q == LAST_ROW) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                doneC      = 1'b1;
                genCount_d = genCount_q + 1'b1;
                state_d    = bus.run ? LOAD_LAST : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset masks the strobes in its own cycle so an aborted sweep commits no further row.
    assign bus.ra        = raC;
    assign bus.wa        = waC;
    assign bus.wd        = wdC;
    assign bus.regwrite  = regwriteC & ~reset;
    assign bus.busy      = busyC & ~reset;
    assign bus.done      = doneC & ~reset;
    assign bus.gen_count = genCount_q;

endmodule
